// File: rtl/lsu_mem_master.sv
// Load/store initiator for the byte-masked data memory: one op at a time, alignment
// checking, lane-replicated store data and sign/zero-extended load results.
module lsu_mem_master #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              op_valid_i,
  output logic              op_ready_o,
  input  logic              op_load_i,
  input  logic              op_store_i,
  input  logic [2:0]        op_funct3_i,
  input  logic [31:0]       op_addr_i,
  input  logic [31:0]       op_wdata_i,
  input  logic [4:0]        op_rd_i,
  output logic              mem_request_o,
  output logic              mem_we_re_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [31:0]       mem_data_in_o,
  output logic [3:0]        mem_mask_o,
  input  logic [31:0]       mem_data_out_i,
  output logic              ld_valid_o,
  output logic [31:0]       ld_data_o,
  output logic [4:0]        ld_rd_o,
  output logic              st_done_o,
  output logic              err_o
);

  typedef enum logic [2:0] {IDLE, REQ, RDATA, RESP, ERR} state_t;

  state_t              state_q;
  logic                op_ready_q;
  logic                mem_request_q, mem_we_re_q;
  logic [ADDR_W-1:0]   mem_address_q;
  logic [31:0]         mem_data_in_q;
  logic [3:0]          mem_mask_q;
  logic                ld_valid_q, st_done_q, err_q;
  logic [31:0]         ld_data_q;
  logic [4:0]          ld_rd_q;
  logic                load_q;
  logic [2:0]          funct3_q;
  logic [1:0]          ofs_q;
  logic [4:0]          rd_q;

  logic                accept_d, illegal_d;
  logic [3:0]          st_mask_d;
  logic [31:0]         st_data_d, ld_ext_d;

  // Upper address bits alias onto the same words.
  logic                unused_addr_bits;
  assign unused_addr_bits = ^op_addr_i[31:ADDR_W+2];

  function automatic logic is_illegal(input logic ld, input logic st,
                                      input logic [2:0] f3, input logic [1:0] ofs);
    logic bad;
    bad = (ld == st);
    if (ld && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)) bad = 1'b1;
    if (st && !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010)) bad = 1'b1;
    if (f3[1:0] == 2'b01 && ofs[0]) bad = 1'b1;
    if (f3[1:0] == 2'b10 && ofs != 2'b00) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] ofs);
    case (size)
      2'b00:   return 4'b0001 << ofs;
      2'b01:   return 4'b0011 << {ofs[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [1:0] ofs);
    logic        [31:0] lane;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    lane = word >> {ofs, 3'b000};
    sb   = lane[7:0];
    sh   = lane[15:0];
    case (f3)
      3'b000:  return 32'(sb);
      3'b001:  return 32'(sh);
      3'b100:  return {24'd0, lane[7:0]};
      3'b101:  return {16'd0, lane[15:0]};
      default: return word;
    endcase
  endfunction

  always_comb begin
    accept_d  = op_valid_i && op_ready_q && (state_q == IDLE);
    illegal_d = is_illegal(op_load_i, op_store_i, op_funct3_i, op_addr_i[1:0]);
    st_mask_d = store_mask(op_funct3_i[1:0], op_addr_i[1:0]);
    st_data_d = store_data(op_funct3_i[1:0], op_wdata_i);
    ld_ext_d  = load_extend(mem_data_out_i, funct3_q, ofs_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      op_ready_q    <= 1'b1;
      mem_request_q <= 1'b0;
      mem_we_re_q   <= 1'b0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      mem_mask_q    <= '0;
      ld_valid_q    <= 1'b0;
      st_done_q     <= 1'b0;
      err_q         <= 1'b0;
      ld_data_q     <= '0;
      ld_rd_q       <= '0;
      load_q        <= 1'b0;
      funct3_q      <= '0;
      ofs_q         <= '0;
      rd_q          <= '0;
    end else begin
      // Memory-side outputs and status pulses default low every cycle.
      mem_request_q <= 1'b0;
      mem_we_re_q   <= 1'b0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      mem_mask_q    <= '0;
      ld_valid_q    <= 1'b0;
      st_done_q     <= 1'b0;
      err_q         <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            op_ready_q <= 1'b0;
            load_q     <= op_load_i;
            funct3_q   <= op_funct3_i;
            ofs_q      <= op_addr_i[1:0];
            rd_q       <= op_rd_i;
            if (illegal_d) begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end else begin
              state_q       <= REQ;
              mem_request_q <= 1'b1;
              mem_we_re_q   <= op_store_i;
              mem_address_q <= op_addr_i[ADDR_W+1:2];
              mem_data_in_q <= op_store_i ? st_data_d : 32'd0;
              mem_mask_q    <= op_store_i ? st_mask_d : 4'd0;
              st_done_q     <= op_store_i;
            end
          end
        end
        REQ: begin
          if (load_q) begin
            state_q <= RDATA;
          end else begin
            state_q    <= IDLE;
            op_ready_q <= 1'b1;
          end
        end
        RDATA: begin
          ld_data_q  <= ld_ext_d;
          ld_rd_q    <= rd_q;
          ld_valid_q <= 1'b1;
          state_q    <= RESP;
        end
        RESP, ERR: begin
          state_q    <= IDLE;
          op_ready_q <= 1'b1;
        end
        default: begin
          state_q    <= IDLE;
          op_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign op_ready_o    = op_ready_q;
  assign mem_request_o = mem_request_q;
  assign mem_we_re_o   = mem_we_re_q;
  assign mem_address_o = mem_address_q;
  assign mem_data_in_o = mem_data_in_q;
  assign mem_mask_o    = mem_mask_q;
  assign ld_valid_o    = ld_valid_q;
  assign ld_data_o     = ld_data_q;
  assign ld_rd_o       = ld_rd_q;
  assign st_done_o     = st_done_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a 1-cycle-latency byte-masked memory model.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        op_valid = 1'b0, op_ready, op_load = 1'b0, op_store = 1'b0;
  logic [2:0]  op_funct3 = '0;
  logic [31:0] op_addr = '0, op_wdata = '0;
  logic [4:0]  op_rd = '0;
  logic        mem_request, mem_we_re;
  logic [7:0]  mem_address;
  logic [31:0] mem_data_in;
  logic [3:0]  mem_mask;
  logic [31:0] mem_data_out = '0;
  logic        ld_valid, st_done, err;
  logic [31:0] ld_data;
  logic [4:0]  ld_rd;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] mem [256];

  always #5 clk = ~clk;

  lsu_mem_master #(.ADDR_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .op_valid_i(op_valid), .op_ready_o(op_ready),
    .op_load_i(op_load), .op_store_i(op_store), .op_funct3_i(op_funct3),
    .op_addr_i(op_addr), .op_wdata_i(op_wdata), .op_rd_i(op_rd),
    .mem_request_o(mem_request), .mem_we_re_o(mem_we_re), .mem_address_o(mem_address),
    .mem_data_in_o(mem_data_in), .mem_mask_o(mem_mask), .mem_data_out_i(mem_data_out),
    .ld_valid_o(ld_valid), .ld_data_o(ld_data), .ld_rd_o(ld_rd),
    .st_done_o(st_done), .err_o(err)
  );

  // Data memory: masked writes, read data registered one cycle after the request.
  always @(posedge clk) begin
    if (mem_request) begin
      if (mem_we_re) begin
        for (int b = 0; b < 4; b++)
          if (mem_mask[b]) mem[mem_address][8*b +: 8] <= mem_data_in[8*b +: 8];
      end else begin
        mem_data_out <= mem[mem_address];
      end
    end
  end

  // Called on a negedge in IDLE; returns on the negedge of the cycle after acceptance.
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    op_valid = 1'b1; op_load = ld; op_store = st; op_funct3 = f3;
    op_addr = a; op_wdata = wd; op_rd = rd;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (op_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_op_ready got=%b exp=1", op_ready); end
    tests_run++;
    if ({mem_request, mem_we_re, mem_mask, ld_valid, st_done, err} !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset_ctrl got=%b exp=0", {mem_request, mem_we_re, mem_mask, ld_valid, st_done, err});
    end
    tests_run++;
    if ({mem_address, mem_data_in, ld_data, ld_rd} !== 77'd0) begin
      tests_failed++;
      $display("FAIL reset_data got addr=%h din=%h ld=%h rd=%0d exp 0", mem_address, mem_data_in, ld_data, ld_rd);
    end
    rst_ni = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store_word();
    issue(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0);
    tests_run++;
    if ({mem_request, mem_we_re, st_done, op_ready} !== 4'b1110) begin
      tests_failed++; $display("FAIL sw_ctrl got=%b exp=1110", {mem_request, mem_we_re, st_done, op_ready});
    end
    tests_run++;
    if (mem_address !== 8'd4 || mem_mask !== 4'b1111 || mem_data_in !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL sw_bus got addr=%0d mask=%b din=%h exp 4 1111 deadbeef", mem_address, mem_mask, mem_data_in);
    end
    @(negedge clk);
    tests_run++;
    if ({op_ready, mem_request, st_done, mem_mask} !== 7'b1000000 || mem_data_in !== 32'd0) begin
      tests_failed++;
      $display("FAIL sw_after got rdy=%b req=%b done=%b mask=%b din=%h", op_ready, mem_request, st_done, mem_mask, mem_data_in);
    end
    tests_run++;
    if (mem[4] !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL sw_mem got=%h exp=deadbeef", mem[4]); end
  endtask

  task automatic test_store_byte();
    issue(1'b0, 1'b1, 3'b000, 32'h13, 32'h000000A5, 5'd0);
    tests_run++;
    if (mem_mask !== 4'b1000 || mem_data_in !== 32'hA5A5A5A5 || st_done !== 1'b1 || mem_address !== 8'd4) begin
      tests_failed++;
      $display("FAIL sb_bus got mask=%b din=%h done=%b addr=%0d exp 1000 a5a5a5a5 1 4", mem_mask, mem_data_in, st_done, mem_address);
    end
    @(negedge clk);
    tests_run++;
    if (mem[4] !== 32'hA5ADBEEF) begin tests_failed++; $display("FAIL sb_mem got=%h exp=a5adbeef", mem[4]); end
  endtask

  task automatic test_loads();
    logic [2:0]  f3  [8] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b101, 3'b010, 3'b010};
    logic [31:0] adr [8] = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h11, 32'h10, 32'h10, 32'h410};
    logic [4:0]  rd  [8] = '{5'd3, 5'd4, 5'd7, 5'd8, 5'd5, 5'd6, 5'd31, 5'd1};
    logic [31:0] exp [8] = '{32'hFFFFFFA5, 32'h000000A5, 32'hFFFFA5AD, 32'h0000A5AD,
                             32'hFFFFFFBE, 32'h0000BEEF, 32'hA5ADBEEF, 32'hA5ADBEEF};
    for (int i = 0; i < 8; i++) begin
      issue(1'b1, 1'b0, f3[i], adr[i], 32'hFFFFFFFF, rd[i]);
      tests_run++;
      if ({mem_request, mem_we_re, mem_mask, st_done} !== 7'b1000000 || mem_data_in !== 32'd0 || mem_address !== 8'd4) begin
        tests_failed++;
        $display("FAIL ld%0d_req got req=%b we=%b mask=%b din=%h addr=%0d", i, mem_request, mem_we_re, mem_mask, mem_data_in, mem_address);
      end
      @(negedge clk);
      tests_run++;
      if (ld_valid !== 1'b0 || mem_request !== 1'b0 || op_ready !== 1'b0) begin
        tests_failed++; $display("FAIL ld%0d_rdata got vld=%b req=%b rdy=%b exp 0 0 0", i, ld_valid, mem_request, op_ready);
      end
      @(negedge clk);
      tests_run++;
      if (ld_valid !== 1'b1 || ld_data !== exp[i] || ld_rd !== rd[i]) begin
        tests_failed++;
        $display("FAIL ld%0d_resp got vld=%b data=%h rd=%0d exp 1 %h %0d", i, ld_valid, ld_data, ld_rd, exp[i], rd[i]);
      end
      @(negedge clk);
      tests_run++;
      if (ld_valid !== 1'b0 || op_ready !== 1'b1 || ld_data !== exp[i]) begin
        tests_failed++; $display("FAIL ld%0d_hold got vld=%b rdy=%b data=%h", i, ld_valid, op_ready, ld_data);
      end
    end
  endtask

  task automatic test_errors();
    logic        ld  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        st  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3  [6] = '{3'b010, 3'b010, 3'b100, 3'b011, 3'b001, 3'b001};
    logic [31:0] adr [6] = '{32'h11, 32'h10, 32'h10, 32'h10, 32'h13, 32'h11};
    for (int i = 0; i < 6; i++) begin
      issue(ld[i], st[i], f3[i], adr[i], 32'h0BADF00D, 5'd2);
      tests_run++;
      if ({err, mem_request, op_ready, st_done} !== 4'b1000) begin
        tests_failed++; $display("FAIL err%0d_pulse got err/req/rdy/done=%b exp=1000", i, {err, mem_request, op_ready, st_done});
      end
      @(negedge clk);
      tests_run++;
      if ({err, mem_request, op_ready, ld_valid} !== 4'b0010) begin
        tests_failed++; $display("FAIL err%0d_after got err/req/rdy/vld=%b exp=0010", i, {err, mem_request, op_ready, ld_valid});
      end
    end
    tests_run++;
    if (mem[4] !== 32'hA5ADBEEF) begin tests_failed++; $display("FAIL err_mem got=%h exp=a5adbeef", mem[4]); end
  endtask

  task automatic test_back_to_back();
    op_valid = 1'b1; op_load = 1'b1; op_store = 1'b0; op_funct3 = 3'b010;
    op_addr = 32'h10; op_wdata = '0; op_rd = 5'd2;
    @(negedge clk);
    tests_run++;
    if (op_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_ld_c1 got rdy=%b exp=0", op_ready); end
    @(negedge clk);
    tests_run++;
    if (op_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_ld_c2 got rdy=%b exp=0", op_ready); end
    @(negedge clk);
    tests_run++;
    if (op_ready !== 1'b0 || ld_valid !== 1'b1 || ld_data !== 32'hA5ADBEEF) begin
      tests_failed++; $display("FAIL b2b_ld_c3 got rdy=%b vld=%b data=%h exp 0 1 a5adbeef", op_ready, ld_valid, ld_data);
    end
    op_load = 1'b0; op_store = 1'b1; op_addr = 32'h20; op_wdata = 32'h12345678;
    @(negedge clk);
    tests_run++;
    if (op_ready !== 1'b1 || mem_request !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_ld_c4 got rdy=%b req=%b exp 1 0", op_ready, mem_request);
    end
    @(negedge clk);
    tests_run++;
    if (op_ready !== 1'b0 || st_done !== 1'b1 || mem_address !== 8'd8) begin
      tests_failed++; $display("FAIL b2b_st_c1 got rdy=%b done=%b addr=%0d exp 0 1 8", op_ready, st_done, mem_address);
    end
    @(negedge clk);
    tests_run++;
    if (op_ready !== 1'b1 || st_done !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_st_c2 got rdy=%b done=%b exp 1 0", op_ready, st_done);
    end
    op_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (mem[8] !== 32'h12345678) begin tests_failed++; $display("FAIL b2b_mem got=%h exp=12345678", mem[8]); end
  endtask

  task automatic test_store_half();
    issue(1'b0, 1'b1, 3'b001, 32'h22, 32'h0000CAFE, 5'd0);
    tests_run++;
    if (mem_mask !== 4'b1100 || mem_data_in !== 32'hCAFECAFE || mem_address !== 8'd8) begin
      tests_failed++;
      $display("FAIL sh_bus got mask=%b din=%h addr=%0d exp 1100 cafecafe 8", mem_mask, mem_data_in, mem_address);
    end
    @(negedge clk);
    tests_run++;
    if (mem[8] !== 32'hCAFE5678) begin tests_failed++; $display("FAIL sh_mem got=%h exp=cafe5678", mem[8]); end
  endtask

  task automatic test_reset_mid_load();
    logic seen;
    issue(1'b1, 1'b0, 3'b010, 32'h20, 32'd0, 5'd9);
    @(negedge clk);
    rst_ni = 1'b0;
    #1;
    tests_run++;
    if ({op_ready, ld_valid, mem_request, err} !== 4'b1000 || ld_data !== 32'd0) begin
      tests_failed++; $display("FAIL rst_mid got rdy/vld/req/err=%b data=%h exp 1000 0", {op_ready, ld_valid, mem_request, err}, ld_data);
    end
    @(negedge clk);
    rst_ni = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ld_valid === 1'b1) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0 || op_ready !== 1'b1) begin
      tests_failed++; $display("FAIL rst_no_vld got seen=%b rdy=%b exp 0 1", seen, op_ready);
    end
    issue(1'b1, 1'b0, 3'b010, 32'h20, 32'd0, 5'd9);
    repeat (2) @(negedge clk);
    tests_run++;
    if (ld_valid !== 1'b1 || ld_data !== 32'hCAFE5678 || ld_rd !== 5'd9) begin
      tests_failed++; $display("FAIL rst_reload got vld=%b data=%h rd=%0d exp 1 cafe5678 9", ld_valid, ld_data, ld_rd);
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    test_reset();
    test_store_word();
    test_store_byte();
    test_loads();
    test_errors();
    test_back_to_back();
    test_store_half();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
